// File: rtl/bids22_pkg.sv
// bids22_pkg: shared types for the bid round sequencer and its datapath.
// Holds the datapath opcode set, the sequencer state encoding and the
// winner codes reported back to the host.
package bids22_pkg;

  typedef enum logic [3:0] {
    NoOp       = 4'h0,
    Unlock     = 4'h1,
    Lock       = 4'h2,
    LoadX      = 4'h3,
    LoadY      = 4'h4,
    LoadZ      = 4'h5,
    SetXYZmask = 4'h6,
    SetTimer   = 4'h7,
    BidCharge  = 4'h8
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG    = 3'd1,
    ROUND  = 3'd2,
    RESULT = 3'd3,
    UNLOCK = 3'd4,
    DONE   = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_X    = 2'd1,
    WIN_Y    = 2'd2,
    WIN_Z    = 2'd3
  } winner_e;

  // Error code reported when the datapath never signals roundOver.
  localparam logic [2:0] SEQ_ERR_TIMEOUT = 3'b111;

  // Index of the final configuration opcode (Lock).
  localparam logic [2:0] CFG_LAST_STEP = 3'd6;

  // A round has a winner only when exactly one win bit is set.
  function automatic winner_e win_code(input logic [2:0] wins_zyx);
    case (wins_zyx)
      3'b001:  win_code = WIN_X;
      3'b010:  win_code = WIN_Y;
      3'b100:  win_code = WIN_Z;
      default: win_code = WIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bid_round_sequencer_if.sv
// bid_round_sequencer_if: command bus and status lines between the
// sequencer (master) and the auction datapath (slave).
interface bid_round_sequencer_if;
  import bids22_pkg::*;

  op_e         C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ready;
  logic [2:0]  err;
  logic        roundOver;
  logic        X_win;
  logic        Y_win;
  logic        Z_win;
  logic [31:0] maxBid;

  modport master (
    output C_op, C_data, C_start,
    input  ready, err, roundOver, X_win, Y_win, Z_win, maxBid
  );

  modport slave (
    input  C_op, C_data, C_start,
    output ready, err, roundOver, X_win, Y_win, Z_win, maxBid
  );

endinterface

// File: rtl/bidseq_cycle_counter.sv
// bidseq_cycle_counter: 16-bit loadable down-counter with zero flag.
// Shared by the round-length timer and the result-wait timeout; the
// counter saturates at zero so a stray decrement never wraps.
module bidseq_cycle_counter (
  input  logic        clk,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        dec_i,
  output logic        zero_o
);

  logic [15:0] cnt_q, cnt_d;

  // Load takes priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Count register; always loaded before it is consulted.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 16'd0);

endmodule

// File: rtl/bid_round_sequencer.sv
// bid_round_sequencer: runs one auction sequence per accepted go --
// configure the datapath, hold C_start for the round, collect the result,
// unlock, and report. Build macro BIDSEQ_TIMEOUT_EN bounds the wait for
// roundOver to RESULT_TIMEOUT cycles; without it the wait is unbounded.
module bid_round_sequencer
  import bids22_pkg::*;
#(
  parameter logic [31:0] LOCK_KEY       = 32'h0F0F0F0F,
  parameter int          RESULT_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [31:0]            cfg_x_fund,
  input  logic [31:0]            cfg_y_fund,
  input  logic [31:0]            cfg_z_fund,
  input  logic [2:0]             cfg_mask,
  input  logic [31:0]            cfg_timer,
  input  logic [31:0]            cfg_cost,
  input  logic [15:0]            cfg_round_len,
  bid_round_sequencer_if.master  dp,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             winner,
  output logic [31:0]            win_amt,
  output logic [2:0]             seq_err
);

  seq_state_e  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        abort_q, abort_d;
  winner_e     winner_q, winner_d;
  logic [31:0] win_amt_q, win_amt_d;
  logic [2:0]  seq_err_q, seq_err_d;

  logic [31:0] x_fund_q, y_fund_q, z_fund_q, timer_q, cost_q;
  logic [2:0]  mask_q;
  logic [15:0] round_len_q;
  logic        cap_cfg;

  logic        cnt_load, cnt_dec, cnt_zero;
  logic [15:0] cnt_val;

  op_e         op_w;
  logic [31:0] data_w;
  logic        start_w;

`ifdef BIDSEQ_TIMEOUT_EN
  localparam logic [15:0] TimeoutLoad = 16'(RESULT_TIMEOUT - 1);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(RESULT_TIMEOUT);
`endif

  // Fixed configuration order issued one opcode per CFG cycle.
  function automatic op_e cfg_op(input logic [2:0] step);
    case (step)
      3'd0:    cfg_op = LoadX;
      3'd1:    cfg_op = LoadY;
      3'd2:    cfg_op = LoadZ;
      3'd3:    cfg_op = SetXYZmask;
      3'd4:    cfg_op = SetTimer;
      3'd5:    cfg_op = BidCharge;
      3'd6:    cfg_op = Lock;
      default: cfg_op = NoOp;
    endcase
  endfunction

  bidseq_cycle_counter u_cnt (
    .clk        (clk),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state, command bus and result capture.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    abort_d   = 1'b0;
    winner_d  = winner_q;
    win_amt_d = win_amt_q;
    seq_err_d = seq_err_q;
    cap_cfg   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = 16'd0;
    op_w      = NoOp;
    data_w    = 32'd0;
    start_w   = 1'b0;

    case (state_q)
      IDLE: begin
        if (go && dp.ready) begin
          state_d   = CFG;
          step_d    = 3'd0;
          cap_cfg   = 1'b1;
          winner_d  = WIN_NONE;
          win_amt_d = 32'd0;
          seq_err_d = 3'd0;
        end
      end

      CFG: begin
        op_w = cfg_op(step_q);
        case (step_q)
          3'd0:    data_w = x_fund_q;
          3'd1:    data_w = y_fund_q;
          3'd2:    data_w = z_fund_q;
          3'd3:    data_w = {29'd0, mask_q};
          3'd4:    data_w = timer_q;
          3'd5:    data_w = cost_q;
          3'd6:    data_w = LOCK_KEY;
          default: data_w = 32'd0;
        endcase
        if (dp.err != 3'd0) begin
          // Datapath rejected this opcode: stop configuring and report.
          seq_err_d = dp.err;
          abort_d   = 1'b1;
          state_d   = IDLE;
        end else if (step_q == CFG_LAST_STEP) begin
          // Round holds for max(len,1) cycles: load len-1 and exit on zero.
          state_d  = ROUND;
          cnt_load = 1'b1;
          cnt_val  = (round_len_q == 16'd0) ? 16'd0 : round_len_q - 16'd1;
        end else begin
          step_d = step_q + 3'd1;
        end
      end

      ROUND: begin
        start_w = 1'b1;
        if (cnt_zero) begin
          state_d = RESULT;
`ifdef BIDSEQ_TIMEOUT_EN
          cnt_load = 1'b1;
          cnt_val  = TimeoutLoad;
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end

      RESULT: begin
        if (dp.roundOver) begin
          winner_d  = win_code({dp.Z_win, dp.Y_win, dp.X_win});
          win_amt_d = (winner_d == WIN_NONE) ? 32'd0 : dp.maxBid;
          state_d   = UNLOCK;
        end
`ifdef BIDSEQ_TIMEOUT_EN
        else if (cnt_zero) begin
          seq_err_d = SEQ_ERR_TIMEOUT;
          winner_d  = WIN_NONE;
          win_amt_d = 32'd0;
          state_d   = UNLOCK;
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end

      UNLOCK: begin
        op_w    = Unlock;
        data_w  = LOCK_KEY;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and reported results; reset abandons any sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      step_q    <= 3'd0;
      abort_q   <= 1'b0;
      winner_q  <= WIN_NONE;
      win_amt_q <= 32'd0;
      seq_err_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      abort_q   <= abort_d;
      winner_q  <= winner_d;
      win_amt_q <= win_amt_d;
      seq_err_q <= seq_err_d;
    end
  end

  // Configuration snapshot taken when go is accepted.
  always_ff @(posedge clk) begin
    if (cap_cfg) begin
      x_fund_q    <= cfg_x_fund;
      y_fund_q    <= cfg_y_fund;
      z_fund_q    <= cfg_z_fund;
      mask_q      <= cfg_mask;
      timer_q     <= cfg_timer;
      cost_q      <= cfg_cost;
      round_len_q <= cfg_round_len;
    end
  end

  assign dp.C_op    = op_w;
  assign dp.C_data  = data_w;
  assign dp.C_start = start_w;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE) | abort_q;
  assign winner  = winner_q;
  assign win_amt = win_amt_q;
  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_bid_round_sequencer.sv
// tb_bid_round_sequencer: directed and randomized sequences checked
// against an expected-behaviour model of the sequencer.
module tb_bid_round_sequencer;

  localparam logic [31:0] KEY = 32'h0F0F0F0F;
  localparam int          TMO = 16;

  localparam logic [3:0] OP_NOOP      = 4'h0;
  localparam logic [3:0] OP_UNLOCK    = 4'h1;
  localparam logic [3:0] OP_LOCK      = 4'h2;
  localparam logic [3:0] OP_LOADX     = 4'h3;
  localparam logic [3:0] OP_LOADY     = 4'h4;
  localparam logic [3:0] OP_LOADZ     = 4'h5;
  localparam logic [3:0] OP_SETMASK   = 4'h6;
  localparam logic [3:0] OP_SETTIMER  = 4'h7;
  localparam logic [3:0] OP_BIDCHARGE = 4'h8;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [31:0] cfg_x_fund, cfg_y_fund, cfg_z_fund, cfg_timer, cfg_cost;
  logic [2:0]  cfg_mask;
  logic [15:0] cfg_round_len;
  logic        busy, done;
  logic [1:0]  winner;
  logic [31:0] win_amt;
  logic [2:0]  seq_err;

  int n_chk  = 0;
  int n_fail = 0;

  bid_round_sequencer_if dp ();

  bid_round_sequencer #(
    .LOCK_KEY       (KEY),
    .RESULT_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .cfg_x_fund    (cfg_x_fund),
    .cfg_y_fund    (cfg_y_fund),
    .cfg_z_fund    (cfg_z_fund),
    .cfg_mask      (cfg_mask),
    .cfg_timer     (cfg_timer),
    .cfg_cost      (cfg_cost),
    .cfg_round_len (cfg_round_len),
    .dp            (dp),
    .busy          (busy),
    .done          (done),
    .winner        (winner),
    .win_amt       (win_amt),
    .seq_err       (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wins = {z, y, x}; a winner exists only when exactly one bit is set.
  function automatic logic [1:0] ref_winner(input logic [2:0] wins);
    if ($countones(wins) != 1) return 2'd0;
    if (wins[0]) return 2'd1;
    if (wins[1]) return 2'd2;
    return 2'd3;
  endfunction

  task automatic scramble_cfg();
    cfg_x_fund    = $urandom;
    cfg_y_fund    = $urandom;
    cfg_z_fund    = $urandom;
    cfg_mask      = 3'($urandom);
    cfg_timer     = $urandom;
    cfg_cost      = $urandom;
    cfg_round_len = 16'($urandom);
  endtask

  task automatic scramble_status();
    dp.X_win  = 1'($urandom);
    dp.Y_win  = 1'($urandom);
    dp.Z_win  = 1'($urandom);
    dp.maxBid = $urandom;
  endtask

  // ro_delay < 0: roundOver never arrives. rst_cyc > 0: reset in that ROUND cycle.
  task automatic run_seq(input logic [31:0] fx, input logic [31:0] fy, input logic [31:0] fz,
                         input logic [2:0] mask, input logic [31:0] timer, input logic [31:0] cost,
                         input logic [15:0] len, input int err_idx, input logic [2:0] errv,
                         input logic [2:0] wins, input logic [31:0] mb, input int ro_delay,
                         input int rst_cyc, input logic go_busy);
    logic [3:0]  eop [7];
    logic [31:0] edat[7];
    logic [1:0]  ewin;
    logic [31:0] eamt;
    logic [2:0]  eerr;
    int          n_start;
    int          exp_len;

    eop[0] = OP_LOADX;     edat[0] = fx;
    eop[1] = OP_LOADY;     edat[1] = fy;
    eop[2] = OP_LOADZ;     edat[2] = fz;
    eop[3] = OP_SETMASK;   edat[3] = {29'd0, mask};
    eop[4] = OP_SETTIMER;  edat[4] = timer;
    eop[5] = OP_BIDCHARGE; edat[5] = cost;
    eop[6] = OP_LOCK;      edat[6] = KEY;

    @(negedge clk);
    check("pre_go_busy", 64'(busy), 64'(0));
    cfg_x_fund = fx; cfg_y_fund = fy; cfg_z_fund = fz;
    cfg_mask = mask; cfg_timer = timer; cfg_cost = cost; cfg_round_len = len;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    scramble_cfg();

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("cfg_op", 64'(dp.C_op), 64'(eop[i]));
      check("cfg_data", 64'(dp.C_data), 64'(edat[i]));
      check("cfg_start", 64'(dp.C_start), 64'(0));
      check("cfg_busy", 64'(busy), 64'(1));
      if (i == 0) begin
        check("go_clears_winner", 64'(winner), 64'(0));
        check("go_clears_amt", 64'(win_amt), 64'(0));
        check("go_clears_err", 64'(seq_err), 64'(0));
      end
      if (go_busy && i == 2) go = 1'b1;
      if (i == err_idx) dp.err = errv;
      @(posedge clk); #1;
      go = 1'b0;
      dp.err = 3'd0;
      if (i == err_idx) begin
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(1));
        check("abort_seq_err", 64'(seq_err), 64'(errv));
        check("abort_op", 64'(dp.C_op), 64'(OP_NOOP));
        check("abort_data", 64'(dp.C_data), 64'(0));
        @(negedge clk);
        check("abort_done_once", 64'(done), 64'(0));
        check("abort_quiet_op", 64'(dp.C_op), 64'(OP_NOOP));
        check("abort_err_held", 64'(seq_err), 64'(errv));
        return;
      end
    end

    n_start = 0;
    exp_len = (len == 16'd0) ? 1 : int'(len);
    for (int guard = 0; guard < 200; guard++) begin
      @(negedge clk);
      if (dp.C_start !== 1'b1) break;
      n_start++;
      check("round_op", 64'(dp.C_op), 64'(OP_NOOP));
      if (rst_cyc != 0 && n_start == rst_cyc) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_start", 64'(dp.C_start), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        for (int q = 0; q < 30; q++) begin
          check("rst_quiet_op", 64'(dp.C_op), 64'(OP_NOOP));
          check("rst_quiet_done", 64'(done), 64'(0));
          @(negedge clk);
        end
        return;
      end
    end
    check("round_len", 64'(n_start), 64'(exp_len));

    if (ro_delay >= 0) begin
      for (int r = 0; r < ro_delay; r++) begin
        check("result_busy", 64'(busy), 64'(1));
        check("result_start", 64'(dp.C_start), 64'(0));
        check("result_op", 64'(dp.C_op), 64'(OP_NOOP));
        @(posedge clk);
        @(negedge clk);
      end
      dp.roundOver = 1'b1;
      dp.X_win = wins[0]; dp.Y_win = wins[1]; dp.Z_win = wins[2];
      dp.maxBid = mb;
      @(posedge clk); #1;
      dp.roundOver = 1'b0;
      scramble_status();
      ewin = ref_winner(wins);
      eamt = (ewin == 2'd0) ? 32'd0 : mb;
      eerr = 3'd0;
    end else begin
`ifdef BIDSEQ_TIMEOUT_EN
      for (int r = 0; r < TMO; r++) begin
        check("tmo_wait_busy", 64'(busy), 64'(1));
        check("tmo_wait_op", 64'(dp.C_op), 64'(OP_NOOP));
        @(posedge clk);
        if (r < TMO - 1) @(negedge clk);
      end
      ewin = 2'd0;
      eamt = 32'd0;
      eerr = 3'b111;
`else
      for (int r = 0; r < 40; r++) begin
        check("stuck_busy", 64'(busy), 64'(1));
        check("stuck_op", 64'(dp.C_op), 64'(OP_NOOP));
        check("stuck_start", 64'(dp.C_start), 64'(0));
        @(negedge clk);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("stuck_rst_busy", 64'(busy), 64'(0));
      check("stuck_rst_done", 64'(done), 64'(0));
      return;
`endif
    end

    @(negedge clk);
    check("unlock_op", 64'(dp.C_op), 64'(OP_UNLOCK));
    check("unlock_data", 64'(dp.C_data), 64'(KEY));
    check("unlock_done", 64'(done), 64'(0));
    check("unlock_seq_err", 64'(seq_err), 64'(eerr));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(1));
    check("done_busy", 64'(busy), 64'(1));
    check("done_op", 64'(dp.C_op), 64'(OP_NOOP));
    check("done_data", 64'(dp.C_data), 64'(0));
    @(negedge clk);
    check("idle_done", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("winner", 64'(winner), 64'(ewin));
    check("win_amt", 64'(win_amt), 64'(eamt));
    check("seq_err", 64'(seq_err), 64'(eerr));
    repeat (2) @(negedge clk);
    check("hold_winner", 64'(winner), 64'(ewin));
    check("hold_win_amt", 64'(win_amt), 64'(eamt));
    check("hold_seq_err", 64'(seq_err), 64'(eerr));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    scramble_cfg();
    dp.ready     = 1'b1;
    dp.err       = 3'd0;
    dp.roundOver = 1'b0;
    scramble_status();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state_busy", 64'(busy), 64'(0));
    check("rst_state_done", 64'(done), 64'(0));
    check("rst_state_winner", 64'(winner), 64'(0));
    check("rst_state_amt", 64'(win_amt), 64'(0));
    check("rst_state_err", 64'(seq_err), 64'(0));
    check("rst_state_op", 64'(dp.C_op), 64'(OP_NOOP));
    check("rst_state_data", 64'(dp.C_data), 64'(0));
    check("rst_state_start", 64'(dp.C_start), 64'(0));
    reset = 1'b0;

    // go while the datapath is not ready is dropped
    @(negedge clk);
    dp.ready = 1'b0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    dp.ready = 1'b1;
    @(negedge clk);
    check("not_ready_busy", 64'(busy), 64'(0));
    check("not_ready_op", 64'(dp.C_op), 64'(OP_NOOP));

    // nominal sequence with a Y win
    run_seq(32'd100, 32'd200, 32'd300, 3'b111, 32'd20, 32'd1, 16'd5,
            -1, 3'd0, 3'b010, 32'd42, 2, 0, 1'b0);
    // datapath error while SetTimer is on the bus
    run_seq(32'd100, 32'd200, 32'd300, 3'b111, 32'd20, 32'd1, 16'd5,
            4, 3'b100, 3'b001, 32'd7, 0, 0, 1'b0);
    // roundOver never arrives
    run_seq(32'd1, 32'd2, 32'd3, 3'b011, 32'd9, 32'd2, 16'd4,
            -1, 3'd0, 3'b000, 32'd0, -1, 0, 1'b0);
    // reset in the third round cycle
    run_seq(32'd5, 32'd6, 32'd7, 3'b101, 32'd8, 32'd3, 16'd8,
            -1, 3'd0, 3'b001, 32'd9, 1, 3, 1'b0);
    // zero round length still starts for one cycle
    run_seq(32'd11, 32'd12, 32'd13, 3'b110, 32'd14, 32'd15, 16'd0,
            -1, 3'd0, 3'b100, 32'd77, 0, 0, 1'b0);
    // go pulsed mid-sequence is ignored
    run_seq(32'd21, 32'd22, 32'd23, 3'b001, 32'd24, 32'd25, 16'd3,
            -1, 3'd0, 3'b001, 32'd55, 1, 0, 1'b1);
    // two win bits: no winner
    run_seq(32'd31, 32'd32, 32'd33, 3'b111, 32'd34, 32'd35, 16'd2,
            -1, 3'd0, 3'b101, 32'd99, 3, 0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      int         ei;
      logic [2:0] ev;
      ei = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      ev = 3'($urandom_range(1, 7));
      run_seq($urandom, $urandom, $urandom, 3'($urandom), $urandom, $urandom,
              16'($urandom_range(0, 9)), ei, ev, 3'($urandom), $urandom,
              int'($urandom_range(0, 10)), 0, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bid_round_sequencer.md
BID_ROUND_SEQUENCER -- requirements
Module: bid_round_sequencer

Interface
REQ-001 SHALL have parameter LOCK_KEY, default 32'h0F0F0F0F: C_data value driven with Lock and with Unlock.
REQ-002 SHALL have parameter RESULT_TIMEOUT, default 16: maximum cycles to wait for roundOver.
REQ-003 SHALL have port clk, in, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, in, 1: reset is synchronous and active-high.
REQ-005 SHALL have port go, in, 1: single-cycle request to run one full auction sequence.
REQ-006 SHALL have ports cfg_x_fund, cfg_y_fund, cfg_z_fund, in, 32 each: starting balances.
REQ-007 SHALL have ports cfg_mask (in, 3), cfg_timer (in, 32) and cfg_cost (in, 32): bidder mask, lockout timer and bid charge.
REQ-008 SHALL have port cfg_round_len, in, 16: number of cycles C_start is held high.
REQ-009 SHALL have ports C_op (out, 4), C_data (out, 32) and C_start (out, 1): command bus to the auction datapath.
REQ-010 SHALL have ports ready (in, 1), err (in, 3), roundOver (in, 1), X_win/Y_win/Z_win (in, 1 each) and maxBid (in, 32): datapath status.
REQ-011 SHALL have ports busy (out, 1), done (out, 1), winner (out, 2), win_amt (out, 32) and seq_err (out, 3): sequencer status and result.

Function
REQ-012 FSM states SHALL be IDLE, CFG, ROUND, RESULT, UNLOCK and DONE.
REQ-013 IDLE: go=1 with ready=1 SHALL go to CFG on the next edge; go is ignored when ready=0 or busy=1.
REQ-014 On go acceptance, all cfg_* inputs SHALL be captured; later changes have no effect on the running sequence.
REQ-015 CFG SHALL drive one opcode per cycle in this fixed order, with 7 cycles total:
- LoadX/cfg_x_fund, LoadY/cfg_y_fund, LoadZ/cfg_z_fund
- SetXYZmask/{29'b0,cfg_mask}, SetTimer/cfg_timer, BidCharge/cfg_cost
- Lock/LOCK_KEY
REQ-016 A nonzero err sampled at the edge ending any CFG cycle SHALL set seq_err=err, abort to IDLE with C_op=NoOp, and pulse done; the remaining opcodes are not issued.
REQ-017 ROUND SHALL drive C_start=1 and C_op=NoOp for exactly max(cfg_round_len,1) cycles, then enter RESULT.
REQ-018 RESULT SHALL hold C_start=0 until roundOver=1 is sampled, then capture the result.
REQ-019 Result capture SHALL follow the win bits:
- exactly one win bit set: winner=1 for X, 2 for Y, 3 for Z, and win_amt=maxBid
- zero or more than one win bit set: winner=0 and win_amt=0
REQ-020 UNLOCK SHALL drive C_op=Unlock and C_data=LOCK_KEY for one cycle, then enter DONE.
REQ-021 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 C_op SHALL be NoOp and C_data SHALL be 0 whenever no opcode is being issued.
REQ-024 winner, win_amt and seq_err SHALL hold their values until the next accepted go, which clears them.

Reset
REQ-025 While reset=1, the FSM SHALL be IDLE and all outputs SHALL be 0 (C_op=NoOp) at the next edge.
REQ-026 reset asserted in any state, mid-sequence included, SHALL abandon the sequence without issuing Unlock and without pulsing done.

Configuration
REQ-027 With BIDSEQ_TIMEOUT_EN defined, RESULT SHALL exit after RESULT_TIMEOUT cycles without roundOver:
- seq_err=3'b111, winner=0
- the sequence then continues to UNLOCK
REQ-028 Without BIDSEQ_TIMEOUT_EN, RESULT SHALL wait indefinitely, and RESULT_TIMEOUT SHALL be unused.

Structure
REQ-029 The opcode enum (NoOp..BidCharge, 4'h0..4'h8), the sequencer state enum and the winner codes SHALL live in shared package bids22_pkg.
REQ-030 A single down-counter sub-module, bidseq_cycle_counter (16-bit load, decrement, zero flag), SHALL time both ROUND length and RESULT timeout.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Nominal: go, funds 100/200/300, mask 3'b111, cost 1, round_len 5 -> 7 CFG ops in order, C_start high exactly 5 cycles, Unlock issued, done pulses once.
- Winner: roundOver with Y_win=1, maxBid=42 -> winner=2, win_amt=42 held after done.
- CFG error: err=3'b100 during SetTimer cycle -> seq_err=3'b100, BidCharge and Lock never driven, return to IDLE.
- Timeout (macro on): roundOver never asserted -> after 16 cycles seq_err=3'b111, Unlock issued; with macro off, FSM stays in RESULT.
- Reset mid-ROUND at cycle 3 -> C_start=0 next edge, no Unlock, no done, busy=0.
- Edge cases: round_len=0 -> C_start high 1 cycle; go during busy -> ignored; two win bits set -> winner=0.
